// File: rtl/fir_output_capture.sv
// Capture sink for the FIR chain: records DEPTH samples of y_in, then replays them over a valid/ready port.
// Optional min/max/clip statistics are compiled in with the CAPTURE_STATS_EN macro.
module fir_output_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8000,
    parameter int ADDR_W = 13,
    parameter int SKIP   = 0
) (
    input  logic                     clk,
    input  logic                     rst_p,
    input  logic                     arm,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic                     y_valid,
    input  logic                     rd_start,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        count,
    output logic [2:0]               dbg_state
`ifdef CAPTURE_STATS_EN
    ,
    output logic signed [DATA_W-1:0] stat_min,
    output logic signed [DATA_W-1:0] stat_max,
    output logic [ADDR_W-1:0]        stat_clip
`endif
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] END_PTR   = ADDR_W'(DEPTH);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

    // dbg_state encoding: 0 idle, 1 skip, 2 capture, 3 full, 4 read
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SKIP    = 3'd1,
        S_CAPTURE = 3'd2,
        S_FULL    = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_ram_q;
    logic                r_ram_v;
    logic                r_ram_last;

    logic w_restart;
    logic w_wr;
    logic w_skip_inc;
    logic w_rd_init;
    logic w_xfer;
    logic w_a_move;
    logic w_issue;

    // Read handshake: a sample moves downstream on every cycle where rd_valid && rd_ready;
    // while rd_valid && !rd_ready, rd_data and rd_last hold. r_ram_q is the prefetch slot
    // that keeps one sample in flight so a continuous rd_ready sees no bubbles.
    assign w_xfer   = rd_valid && rd_ready;
    assign w_a_move = r_ram_v && (!rd_valid || w_xfer);
    assign w_issue  = (r_state == S_READ) && (r_rd_ptr != END_PTR) && (!r_ram_v || w_a_move);

    assign busy      = (r_state == S_SKIP) || (r_state == S_CAPTURE);
    assign done      = (r_state == S_FULL) || (r_state == S_READ);
    assign dbg_state = r_state;

    always_comb begin
        w_next     = r_state;
        w_restart  = 1'b0;
        w_wr       = 1'b0;
        w_skip_inc = 1'b0;
        w_rd_init  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) w_restart = 1'b1;
            end
            S_SKIP: begin
                if (arm) begin
                    w_restart = 1'b1;
                end else if (y_valid) begin
                    w_skip_inc = 1'b1;
                    if (r_skip_cnt == SKIP_LAST) w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (arm) begin
                    w_restart = 1'b1;
                end else if (y_valid) begin
                    w_wr = 1'b1;
                    if (r_count_at_last()) w_next = S_FULL;
                end
            end
            S_FULL: begin
                if (arm) begin
                    w_restart = 1'b1;
                end else if (rd_start) begin
                    w_rd_init = 1'b1;
                    w_next    = S_READ;
                end
            end
            S_READ: begin
                if (w_xfer && rd_last) w_next = S_FULL;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_restart) w_next = (SKIP > 0) ? S_SKIP : S_CAPTURE;
    end

    function automatic logic r_count_at_last();
        return count == LAST_IDX;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state    <= S_IDLE;
            count      <= '0;
            r_skip_cnt <= '0;
            r_rd_ptr   <= '0;
            r_ram_v    <= 1'b0;
            r_ram_last <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                count      <= '0;
                r_skip_cnt <= '0;
            end else begin
                if (w_wr)       count      <= count + ADDR_W'(1);
                if (w_skip_inc) r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
            end

            if (w_rd_init) begin
                r_rd_ptr   <= '0;
                r_ram_v    <= 1'b0;
                r_ram_last <= 1'b0;
                rd_valid   <= 1'b0;
                rd_last    <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                    r_ram_v    <= 1'b1;
                    r_ram_last <= (r_rd_ptr == LAST_IDX);
                end else if (w_a_move) begin
                    r_ram_v <= 1'b0;
                end
                if (w_a_move) begin
                    rd_data  <= r_ram_q;
                    rd_valid <= 1'b1;
                    rd_last  <= r_ram_last;
                end else if (w_xfer) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end
        end
    end

    // Sample buffer: contents survive reset, read data registered once per issue.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[count[MEM_AW-1:0]] <= y_in;
        if (w_issue) r_ram_q <= r_mem[r_rd_ptr[MEM_AW-1:0]];
    end

`ifdef CAPTURE_STATS_EN
    localparam logic signed [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst_p || w_restart) begin
            stat_min  <= POS_MAX;
            stat_max  <= NEG_MAX;
            stat_clip <= '0;
        end else if (w_wr) begin
            if (y_in < stat_min) stat_min <= y_in;
            if (y_in > stat_max) stat_max <= y_in;
            if ((y_in == POS_MAX) || (y_in == NEG_MAX)) stat_clip <= stat_clip + ADDR_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_fir_output_capture.sv
// Bench for fir_output_capture: two instances (SKIP=0 and SKIP=3) share one stimulus stream and are
// checked against a queue model of "valid samples since the last arm".
module tb_fir_output_capture;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_p;
    logic              arm;
    logic [DATA_W-1:0] y_in;
    logic              y_valid;
    logic              rd_start;
    logic              rd_ready;

    logic [DATA_W-1:0] rd_data0, rd_data3;
    logic              rd_valid0, rd_valid3;
    logic              rd_last0, rd_last3;
    logic              busy0, busy3;
    logic              done0, done3;
    logic [ADDR_W-1:0] count0, count3;
    logic [2:0]        state0, state3;
`ifdef CAPTURE_STATS_EN
    logic [DATA_W-1:0] smin0, smin3, smax0, smax3;
    logic [ADDR_W-1:0] sclip0, sclip3;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: samples accepted since the last arm, per instance.
    logic [DATA_W-1:0] h0[$];
    logic [DATA_W-1:0] h3[$];
    bit                m_armed;

    always #5 clk = ~clk;

    fir_output_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP(0)) u_dut0 (
        .clk(clk), .rst_p(rst_p), .arm(arm), .y_in(y_in), .y_valid(y_valid),
        .rd_start(rd_start), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
        .rd_last(rd_last0), .busy(busy0), .done(done0), .count(count0), .dbg_state(state0)
`ifdef CAPTURE_STATS_EN
        , .stat_min(smin0), .stat_max(smax0), .stat_clip(sclip0)
`endif
    );

    fir_output_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP(3)) u_dut3 (
        .clk(clk), .rst_p(rst_p), .arm(arm), .y_in(y_in), .y_valid(y_valid),
        .rd_start(rd_start), .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_ready(rd_ready),
        .rd_last(rd_last3), .busy(busy3), .done(done3), .count(count3), .dbg_state(state3)
`ifdef CAPTURE_STATS_EN
        , .stat_min(smin3), .stat_max(smax3), .stat_clip(sclip3)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hsize(input int k);
        return (k == 0) ? h0.size() : h3.size();
    endfunction

    function automatic int skipk(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit complete(input int k);
        return m_armed && (hsize(k) >= skipk(k) + DEPTH);
    endfunction

    function automatic int exp_count(input int k);
        int n;
        n = hsize(k) - skipk(k);
        if (n < 0) n = 0;
        if (n > DEPTH) n = DEPTH;
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] exp_at(input int k, input int i);
        if (k == 0) return h0[i];
        return h3[3 + i];
    endfunction

    task automatic check_status();
        check("count0", count0, exp_count(0));
        check("busy0", busy0, m_armed && !complete(0));
        check("done0", done0, complete(0));
        check("count3", count3, exp_count(3));
        check("busy3", busy3, m_armed && !complete(3));
        check("done3", done3, complete(3));
    endtask

    // One capture-side cycle; the model follows the arm / valid rules at the same edge.
    task automatic cap_cycle(input logic a, input logic v, input logic [DATA_W-1:0] y);
        arm = a; y_valid = v; y_in = y;
        step();
        arm = 1'b0; y_valid = 1'b0;
        if (a) begin
            m_armed = 1'b1;
            h0.delete();
            h3.delete();
        end else if (v && m_armed) begin
            if (!complete(0)) h0.push_back(y);
            if (!complete(3)) h3.push_back(y);
        end
        check_status();
    endtask

    task automatic do_reset();
        rst_p = 1'b1; arm = 1'b0; y_valid = 1'b0; rd_start = 1'b0;
        step();
        m_armed = 1'b0;
        h0.delete();
        h3.delete();
        check("rst_rd_data0", rd_data0, 0);
        check("rst_rd_valid0", rd_valid0, 0);
        check("rst_rd_last0", rd_last0, 0);
        check("rst_state0", state0, 0);
        check("rst_rd_data3", rd_data3, 0);
        check("rst_rd_valid3", rd_valid3, 0);
        check("rst_rd_last3", rd_last3, 0);
        check("rst_state3", state3, 0);
        check_status();
        rst_p = 1'b0;
    endtask

    task automatic rd_ignored(input string tag);
        rd_ready = 1'b1; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        repeat (3) step();
        check({tag, "_valid0"}, rd_valid0, 0);
        check({tag, "_valid3"}, rd_valid3, 0);
        check({tag, "_done0"}, done0, 0);
    endtask

    task automatic fill_random(input int gap_max);
        int guard;
        guard = 0;
        while (!complete(3) && guard < 500) begin
            cap_cycle(1'b0, (gap_max == 0) ? 1'b1 : ($urandom_range(0, gap_max) == 0), 16'($urandom));
            guard++;
        end
        check("fill_budget", guard < 500, 1);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 with an arm pulse mid-read; 2: random ready
    task automatic do_read(input int mode);
        int   idx, cyc, bubbles, lasts;
        logic v0, l0, r;
        idx = 0; cyc = 0; bubbles = 0; lasts = 0;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("rd_lat0_valid0", rd_valid0, 0);
        step();
        check("rd_lat1_valid0", rd_valid0, 0);
        check("rd_lat1_valid3", rd_valid3, 0);
        step();
        check("rd_lat2_valid0", rd_valid0, 1);
        check("rd_lat2_valid3", rd_valid3, 1);
        while (idx < DEPTH && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rd_ready = r;
            arm = (mode == 1 && cyc == 2);
            v0 = rd_valid0;
            l0 = rd_last0;
            if (v0) begin
                check("rd_data0", rd_data0, exp_at(0, idx));
                check("rd_last0", rd_last0, idx == DEPTH - 1);
                check("rd_valid3", rd_valid3, 1);
                check("rd_data3", rd_data3, exp_at(3, idx));
                check("rd_last3", rd_last3, idx == DEPTH - 1);
            end else begin
                bubbles++;
            end
            step();
            cyc++;
            if (v0 && r) begin
                idx++;
                if (l0) lasts++;
            end
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        check("rd_all_taken", idx, DEPTH);
        check("rd_end_valid0", rd_valid0, 0);
        check("rd_end_valid3", rd_valid3, 0);
        check("rd_end_done0", done0, 1);
        check("rd_end_done3", done3, 1);
        check("rd_end_busy0", busy0, 0);
        check("rd_last_once", lasts, 1);
        if (mode == 0) check("rd_no_bubble", bubbles, 0);
    endtask

`ifdef CAPTURE_STATS_EN
    task automatic check_stats(input int k);
        logic signed [DATA_W-1:0] s, mn, mx;
        int clip;
        mn = 16'sh7FFF; mx = -16'sh8000; clip = 0;
        for (int i = 0; i < DEPTH; i++) begin
            s = exp_at(k, i);
            if (s < mn) mn = s;
            if (s > mx) mx = s;
            if (s == 16'sh7FFF || s == -16'sh8000) clip++;
        end
        if (k == 0) begin
            check("stat_min0", smin0, 32'(mn) & 32'hFFFF);
            check("stat_max0", smax0, 32'(mx) & 32'hFFFF);
            check("stat_clip0", sclip0, clip);
        end else begin
            check("stat_min3", smin3, 32'(mn) & 32'hFFFF);
            check("stat_max3", smax3, 32'(mx) & 32'hFFFF);
            check("stat_clip3", sclip3, clip);
        end
    endtask
`endif

    initial begin
        int n;
        rst_p = 1'b1; arm = 1'b0; y_in = '0; y_valid = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        m_armed = 1'b0;
        step();
        do_reset();
        rd_ignored("idle_rd");

        // Run 1: 1..11 continuous; SKIP=0 keeps 1..8, SKIP=3 keeps 4..11.
        cap_cycle(1'b1, 1'b0, '0);
        for (int v = 1; v <= 11; v++) cap_cycle(1'b0, 1'b1, 16'(v));
        do_read(0);

        // Run 2: -5..+10, armed from FULL; stalled readout then a replay.
        cap_cycle(1'b1, 1'b0, '0);
        for (int v = -5; v <= 10; v++) cap_cycle(1'b0, 1'b1, 16'(v));
        do_read(1);
        do_read(0);

        // Run 3: valid every 3rd cycle, re-armed after 4 samples with a coincident valid.
        cap_cycle(1'b1, 1'b0, '0);
        n = 0;
        for (int c = 0; n < 4 && c < 50; c++) begin
            cap_cycle(1'b0, (c % 3 == 2), 16'(100 + c));
            if (c % 3 == 2) n++;
        end
        check("rearm_count_before", count0, 4);
        cap_cycle(1'b1, 1'b1, 16'h7777);
        for (int c = 0; c < 300 && !complete(3); c++) cap_cycle(1'b0, (c % 3 == 2), 16'(200 + c));
        check("gap_fill_done3", done3, 1);
        do_read(2);

        // Reset mid-capture, then mid-readout.
        cap_cycle(1'b1, 1'b0, '0);
        repeat (3) cap_cycle(1'b0, 1'b1, 16'($urandom));
        do_reset();
        rd_ignored("cap_rst_rd");
        cap_cycle(1'b1, 1'b0, '0);
        fill_random(0);
        rd_ready = 1'b1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        check("midread_valid0", rd_valid0, 1);
        do_reset();
        rd_ignored("rd_rst_rd");

        // Randomised runs: random data, random valid gaps, random back-pressure.
        for (int r = 0; r < 3; r++) begin
            cap_cycle(1'b1, 1'b0, '0);
            fill_random(2);
            do_read(2);
        end

`ifdef CAPTURE_STATS_EN
        cap_cycle(1'b1, 1'b0, '0);
        check("stat_init_min0", smin0, 16'h7FFF);
        check("stat_init_max0", smax0, 16'h8000);
        check("stat_init_clip0", sclip0, 0);
        begin
            logic [DATA_W-1:0] vals[$];
            vals = '{16'd1, 16'd2, 16'd3, 16'd100, 16'h8000, 16'h7FFF, 16'hFFF9,
                     16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
            foreach (vals[i]) cap_cycle(1'b0, 1'b1, vals[i]);
        end
        check_stats(0);
        check_stats(3);
        do_read(0);
        check_stats(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
